// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin 8:1 mux scheduler.
package mux_sched_pkg;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Result of one round-robin scan: whether anybody is requesting, and who.
  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // First set bit of req scanning upward from ptr (mod NREQ); ptr has top priority.
  // The scan runs from the farthest offset down to offset 0 so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [SELW-1:0] ptr);
    pick_t           r;
    logic [SELW-1:0] k;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + SELW'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_1.sv
// Purely combinational 8:1 single-bit mux; select is {s2,s1,s0}.
module mux8_1 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic y
);

  // Route the selected input to y.
  always_comb begin
    y = a;
    case ({s2, s1, s0})
      3'd0:    y = a;
      3'd1:    y = b;
      3'd2:    y = c;
      3'd3:    y = d;
      3'd4:    y = e;
      3'd5:    y = f;
      3'd6:    y = g;
      3'd7:    y = h;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rr_mux8_sched.sv
// Round-robin scheduler sharing one 8:1 mux among eight 1-bit producers.
//
// Output handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready, and while
// out_ready is low the grant, select and burst count are held unchanged.
// ack[i] marks the cycle in which requester i's bit is taken.
//
// BURST must be in 1..15 and 2**CW must exceed BURST.
module rr_mux8_sched
  import mux_sched_pkg::*;
#(
  parameter int BURST = 1,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic [SELW-1:0] sel,
  output logic            out_valid,
  output logic            y,
  output logic            busy,
  output state_e          dbg_state
);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [SELW-1:0] sel_q,   sel_d;

  logic            xfer;
  logic            burst_more;
  logic [SELW-1:0] ptr_next;
  pick_t           pick_cur;
  pick_t           pick_adv;

  // Two candidate scans: from the held pointer (idle / abort) and from the
  // slot just after the current owner (normal hand-over after a transfer).
  always_comb begin
    ptr_next   = sel_q + SELW'(1);
    pick_cur   = rr_pick(req, ptr_q);
    pick_adv   = rr_pick(req, ptr_next);
    xfer       = (state_q == GRANT) && out_ready;
    burst_more = req[sel_q] && (cnt_q < CW'(BURST));
  end

  // Next-state logic: grant loading, burst continuation, hand-over and abort.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pick_cur.found) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_cur.idx);
          sel_d   = pick_cur.idx;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (xfer) begin
          if (burst_more) begin
            // Same owner keeps the mux for another back-to-back bit.
            cnt_d = cnt_q + CW'(1);
          end else begin
            // Owner drops to lowest priority; hand over with no bubble.
            ptr_d = ptr_next;
            if (pick_adv.found) begin
              gnt_d = onehot(pick_adv.idx);
              sel_d = pick_adv.idx;
              cnt_d = CW'(1);
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
              sel_d   = '0;
              cnt_d   = '0;
            end
          end
        end else if (!req[sel_q]) begin
          // Owner withdrew without transferring: abort, pointer untouched.
          if (pick_cur.found) begin
            gnt_d = onehot(pick_cur.idx);
            sel_d = pick_cur.idx;
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  // Shared data mux driven by the registered select.
  mux8_1 u_mux (
    .a  (din[0]),
    .b  (din[1]),
    .c  (din[2]),
    .d  (din[3]),
    .e  (din[4]),
    .f  (din[5]),
    .g  (din[6]),
    .h  (din[7]),
    .s0 (sel_q[0]),
    .s1 (sel_q[1]),
    .s2 (sel_q[2]),
    .y  (y)
  );

  // Output decode; ack is gated by out_valid so it can never appear while idle.
  always_comb begin
    out_valid = (state_q == GRANT);
    busy      = (state_q == GRANT);
    gnt       = gnt_q;
    sel       = sel_q;
    ack       = out_valid ? (gnt_q & {NREQ{out_ready}}) : '0;
    dbg_state = state_q;
  end

  // Structural invariants on the registered grant and burst count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      if (state_q == GRANT) begin
        assert (gnt_q == onehot(sel_q));
        assert (cnt_q != '0 && cnt_q <= CW'(BURST));
      end else begin
        assert (gnt_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_rr_mux8_sched.sv
// Directed bench for rr_mux8_sched: one instance with BURST=1, one with BURST=3.
module tb_rr_mux8_sched;
  import mux_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with BURST=1 ----------------
  logic [7:0] req1, din1, gnt1, ack1;
  logic [2:0] sel1;
  logic       rdy1, valid1, y1, busy1;
  state_e     st1;

  rr_mux8_sched #(.BURST(1), .CW(4)) u_b1 (
    .clk(clk), .rst(rst), .req(req1), .din(din1), .out_ready(rdy1),
    .gnt(gnt1), .ack(ack1), .sel(sel1), .out_valid(valid1), .y(y1),
    .busy(busy1), .dbg_state(st1)
  );

  // ---------------- DUT with BURST=3 ----------------
  logic [7:0] req3, din3, gnt3, ack3;
  logic [2:0] sel3;
  logic       rdy3, valid3, y3, busy3;
  state_e     st3;

  rr_mux8_sched #(.BURST(3), .CW(2)) u_b3 (
    .clk(clk), .rst(rst), .req(req3), .din(din3), .out_ready(rdy3),
    .gnt(gnt3), .ack(ack3), .sel(sel3), .out_valid(valid3), .y(y3),
    .busy(busy3), .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  // Entry = {requester index, data bit} of one expected transfer.
  logic [3:0] exp1_q[$];
  logic [3:0] exp3_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [2:0] s);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got transfer from sel %0d expected none at %0t", name, s, $time);
  endtask

  // Monitor: every presented transfer is popped and compared mid-cycle.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst) begin
      if (!valid1) check("b1_ack_idle", ack1, 8'h00);
      else if (ack1 != 8'h00) begin
        if (exp1_q.size() == 0) unexpected("b1_xfer", sel1);
        else begin
          e = exp1_q.pop_front();
          check("b1_xfer", {4'b0, sel1, y1}, {4'b0, e});
          check("b1_ack", ack1, 8'(1) << e[3:1]);
        end
      end
      if (!valid3) check("b3_ack_idle", ack3, 8'h00);
      else if (ack3 != 8'h00) begin
        if (exp3_q.size() == 0) unexpected("b3_xfer", sel3);
        else begin
          e = exp3_q.pop_front();
          check("b3_xfer", {4'b0, sel3, y3}, {4'b0, e});
          check("b3_ack", ack3, 8'(1) << e[3:1]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push1(input logic [2:0] idx, input logic b);
    exp1_q.push_back({idx, b});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rr_din;
    logic [2:0] bidx;
    rr_din = 8'b1001_1110;
    req1 = 8'hFF; din1 = rr_din; rdy1 = 1'b1;
    req3 = 8'h00; din3 = 8'h00; rdy3 = 1'b0;

    // Reset held with all requests up.
    step(); step(); mid();
    check("rst_gnt", gnt1, 8'h00);
    check("rst_valid", {7'b0, valid1}, 8'h00);
    check("rst_sel", {5'b0, sel1}, 8'h00);
    check("rst_busy", {7'b0, busy1}, 8'h00);
    check("rst_b3_valid", {7'b0, valid3}, 8'h00);

    // Release reset: 0..7 then 0 again, one transfer per cycle.
    step(); rst = 1'b0;
    for (int k = 0; k < 9; k++) push1(3'(k % 8), rr_din[k % 8]);
    mid();
    check("lat_valid_pending", {7'b0, valid1}, 8'h00);
    step(); mid();
    check("first_sel", {5'b0, sel1}, 8'h00);
    check("first_gnt", gnt1, 8'h01);
    for (int k = 1; k < 9; k++) begin
      step();
      if (k == 8) req1 = 8'h00;
      mid();
    end
    step(); mid();
    check("rr_idle", {7'b0, valid1}, 8'h00);
    check("rr_q_empty", 8'(exp1_q.size()), 8'h00);

    // Backpressure: ptr=1, req 2 and 5, consumer stalls.
    step(); req1 = 8'h24; rdy1 = 1'b0; din1 = 8'h04;
    mid();
    check("bp_pre_valid", {7'b0, valid1}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(); mid();
      check("bp_sel", {5'b0, sel1}, 8'h02);
      check("bp_valid", {7'b0, valid1}, 8'h01);
      check("bp_ack", ack1, 8'h00);
    end
    step(); rdy1 = 1'b1; push1(3'd2, 1'b1);
    mid();
    check("bp_release_ack", ack1, 8'h04);
    step(); req1 = 8'h00; push1(3'd5, 1'b0);
    mid();
    check("bp_next_sel", {5'b0, sel1}, 8'h05);
    step(); mid();
    check("bp_idle", {7'b0, valid1}, 8'h00);
    check("bp_q_empty", 8'(exp1_q.size()), 8'h00);

    // Wrap: ptr=6, serve 6, pointer moves to 7, requester 1 wins across the wrap.
    step(); req1 = 8'h40; din1 = 8'h42; push1(3'd6, 1'b1);
    mid();
    step(); req1 = 8'h02; push1(3'd1, 1'b1);
    mid();
    check("wrap_sel6", {5'b0, sel1}, 8'h06);
    step(); req1 = 8'h00;
    mid();
    check("wrap_sel1", {5'b0, sel1}, 8'h01);
    step(); mid();
    check("wrap_idle", {7'b0, valid1}, 8'h00);
    check("wrap_q_empty", 8'(exp1_q.size()), 8'h00);

    // Abort: ptr=2, requester 3 granted then withdraws while stalled.
    step(); req1 = 8'h08; rdy1 = 1'b0; din1 = 8'h08;
    mid();
    step(); mid();
    check("abort_sel", {5'b0, sel1}, 8'h03);
    check("abort_valid", {7'b0, valid1}, 8'h01);
    step(); req1 = 8'h00;
    mid();
    check("abort_noack", ack1, 8'h00);
    step(); req1 = 8'h0A; rdy1 = 1'b1;
    mid();
    check("abort_valid_drop", {7'b0, valid1}, 8'h00);
    // Pointer still 2, so 3 beats 1.
    step(); rdy1 = 1'b0; rst = 1'b1;
    mid();
    check("abort_ptr_kept", {5'b0, sel1}, 8'h03);
    check("midrst_noack", ack1, 8'h00);
    step(); rst = 1'b0; req1 = 8'h82; rdy1 = 1'b1; din1 = 8'h00;
    mid();
    check("midrst_gnt", gnt1, 8'h00);
    check("midrst_valid", {7'b0, valid1}, 8'h00);
    check("midrst_sel", {5'b0, sel1}, 8'h00);
    check("midrst_busy", {7'b0, busy1}, 8'h00);
    // Pointer reset to 0, so 1 beats 7.
    step(); req1 = 8'h00; push1(3'd1, 1'b0);
    mid();
    check("midrst_ptr0", {5'b0, sel1}, 8'h01);
    step(); mid();
    check("midrst_idle", {7'b0, valid1}, 8'h00);
    check("midrst_q_empty", 8'(exp1_q.size()), 8'h00);

    // Burst of 3 on the second instance: 0,0,0,7,7,7,0,0,0,7.
    step(); req3 = 8'h81; rdy3 = 1'b1; din3 = 8'h80;
    for (int k = 0; k < 10; k++) begin
      bidx = ((k / 3) % 2 == 1) ? 3'd7 : 3'd0;
      exp3_q.push_back({bidx, bidx == 3'd7});
    end
    mid();
    step(); mid();
    check("burst_first_sel", {5'b0, sel3}, 8'h00);
    for (int k = 1; k < 10; k++) begin
      step();
      if (k == 9) req3 = 8'h00;
      mid();
    end
    step(); mid();
    check("burst_idle", {7'b0, valid3}, 8'h00);
    check("burst_q_empty", 8'(exp3_q.size()), 8'h00);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mux8_sched.md
Name: rr_mux8_sched

Overview:
- Round-robin scheduler that shares one 8:1 single-bit data mux among 8 requesters and drives its select lines (s2,s1,s0).
- Presents the selected requester's bit on one valid/ready output channel.
- Sits between eight 1-bit producers and a single downstream consumer.
- Supports an optional burst allowance per grant.

Parameters:
- BURST, 1, max consecutive transfers one requester may make per grant (1..15).
- CW, 4, width of the burst counter; must satisfy 2**CW > BURST.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request per requester; bit i maps to mux input i (a=0 ... h=7).
- din  in  8  data bit per requester; din[i] is valid while req[i]=1.
- out_ready  in  1  consumer can accept y this cycle.
- gnt  out  8  one-hot registered grant; all zero when idle.
- ack  out  8  one-hot; ack[i]=gnt[i]&out_ready; marks the cycle requester i's bit transferred.
- sel  out  3  registered mux select {s2,s1,s0} = index of the granted requester.
- out_valid  out  1  y holds a valid transfer.
- y  out  1  din[sel], combinational through the mux.
- busy  out  1  FSM is in GRANT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: gnt=0, sel=0, out_valid=0, busy=0, ptr=0, burst count=0, state=IDLE.
- Reset mid-transfer drops the grant on the next edge without producing an ack. rst has priority over all other events.
- States: IDLE and GRANT.
- Arbitration function: pick the first set bit of req, scanning from index ptr upward mod 8. ptr itself is the highest priority.
- IDLE:
  - If req!=0, register the winner: gnt=onehot(w), sel=w, count=1, then go to GRANT.
  - Latency is 1 cycle: a req raised at edge N gives gnt/out_valid high after edge N+1.
  - If req=0, stay in IDLE with all outputs 0.
- GRANT:
  - out_valid=1 and y=din[sel].
  - If out_ready=0, hold gnt, sel and count unchanged (stall), for any duration.
  - On a transfer (out_valid & out_ready):
    - If req[sel] is still 1 and count<BURST: keep the grant, count+1. This gives back-to-back transfers with no bubble.
    - Otherwise: ptr=(sel+1) mod 8, then re-arbitrate in the same cycle using the current req and the new ptr. The current requester is not masked but now has lowest priority.
    - If the re-arbitration has a winner, load it (count=1) and stay in GRANT with no bubble cycle. If not, go to IDLE.
  - If req[sel] drops while granted with no transfer (protocol violation): abort, clear out_valid next cycle, leave ptr unchanged, and re-arbitrate as above.
- Wrap-around: ptr increments mod 8, so 7 wraps to 0. sel is a 3-bit unsigned value.
- Requirements on requesters and consumer:
  - Requesters hold req and a stable din until acked.
  - The consumer may toggle out_ready freely.
- Invariants:
  - gnt is always zero or one-hot, and equals onehot(sel) whenever out_valid=1.
  - ack is never set when out_valid=0.
  - With req saturated, each requester receives ≤BURST transfers before every other active requester is served once.

Decomposition:
- Shared package mux_sched_pkg holds:
  - constant NREQ=8 and SELW=3;
  - state enum {IDLE, GRANT};
  - function rr_pick(req, ptr), returning {found, idx}.
- One natural sub-module: mux8_1, a purely combinational 8:1 single-bit mux (inputs a..h, s0..s2, output y), instantiated to form y from din and sel.

Test Plan:
- Reset check: rst high for 2 cycles with req=8'hFF → gnt=0, out_valid=0, sel=0. Release rst, out_ready=1 → first grant is sel=0 one cycle later.
- Round-robin order: BURST=1, req=8'hFF held, out_ready=1, din=8'b1001_1110 → sel sequence 0,1,...,7,0; y sequence 0,1,1,1,1,0,0,1; one ack per cycle, no bubbles.
- Backpressure: req=8'h24, out_ready low for 5 cycles → sel=2 is held stable with out_valid=1 and ack=0. Raise out_ready → ack=8'h04, then sel=5 next cycle.
- Burst: BURST=3, req=8'h81 held → transfers go 0,0,0,7,7,7,0,...
- Wrap and gaps: ptr=7 (after serving 6), req=8'h02 only → sel=1. Then req=0 → FSM returns to IDLE and out_valid=0 the cycle after the final ack.
- Abort and reset mid-operation: drop req[sel] while out_ready=0 → out_valid falls next cycle, no ack, ptr unchanged. Assert rst during GRANT → all outputs zero after the edge.
